// File: rtl/cam_cap_pkg.sv
// Shared definitions for the camera capture front end.
//   cap_state_e  : capture FSM states
//   *_DEF        : default widths and sizes used as top-level parameter defaults
//   BYTES_PX_MAX : largest supported number of bus words per pixel
//   BCNT_W       : width of the per-pixel byte counter
package cam_cap_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int BYTES_PX_DEF = 2;
  localparam int H_PIX_DEF    = 256;
  localparam int V_PIX_DEF    = 128;
  localparam int SRC_W_DEF    = 11;
  localparam int BYTES_PX_MAX = 4;
  localparam int BCNT_W       = $clog2(BYTES_PX_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_FR = 3'd2,
    ACTIVE  = 3'd3,
    DONE    = 3'd4
  } cap_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for the asynchronous camera bus plus PCLK rise detect.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   pclk_i   : camera pixel clock (asynchronous)
//   d_i      : camera data
//   hin_i    : line valid
//   vin_i    : vertical blanking
//   d_o      : synchronised data, aligned with sample_o
//   hin_o    : synchronised line valid, aligned with sample_o
//   vin_o    : synchronised vertical blanking, aligned with sample_o
//   sample_o : one-cycle strobe on a 0->1 transition of synchronised PCLK
module cam_sync_edge #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pclk_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              hin_i,
  input  logic              vin_i,
  output logic [DATA_W-1:0] d_o,
  output logic              hin_o,
  output logic              vin_o,
  output logic              sample_o
);

  localparam int BUS_W = DATA_W + 2;

  logic [BUS_W-1:0] bus_s1_q, bus_s2_q;
  logic             pclk_s1_q, pclk_s2_q, pclk_s3_q;

  // Data travels through the same two stages as PCLK so that the bus seen at
  // a sample strobe is the one that was stable at the PCLK rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pclk_s1_q <= 1'b0;
      pclk_s2_q <= 1'b0;
      pclk_s3_q <= 1'b0;
      bus_s1_q  <= '0;
      bus_s2_q  <= '0;
    end else begin
      pclk_s1_q <= pclk_i;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      bus_s1_q  <= {d_i, hin_i, vin_i};
      bus_s2_q  <= bus_s1_q;
    end
  end

  assign sample_o            = pclk_s2_q & ~pclk_s3_q;
  assign {d_o, hin_o, vin_o} = bus_s2_q;

endmodule

// File: rtl/cam_frame_capture.sv
// Camera capture front end: samples an asynchronous camera bus, assembles
// multi-word pixels, decimates 1/2/4/8 in both axes and writes the result
// into a frame buffer.
// Optional feature macro: CAP_WINDOW_EN adds a capture window origin
// (WIN_X0, WIN_Y0); without it the origin is fixed at (0,0).
// Ports:
//   CLK, RSTN        : system clock, asynchronous active-low reset
//   PCLK, D, HIN, VIN: asynchronous camera bus
//   ARM              : one-cycle capture start pulse (accepted in IDLE only)
//   MODE             : 0 single-shot, 1 continuous (sampled at frame end)
//   DECIM            : log2 decimation factor, latched at frame start
//   WIN_X0, WIN_Y0   : window origin, latched at frame start (CAP_WINDOW_EN)
//   WE               : frame buffer write strobe
//   WADDR_X, WADDR_Y : destination column / line
//   WDATA            : assembled pixel, first bus word in the MSBs
//   BUSY             : FSM not idle
//   FRAME_DONE       : one-cycle pulse at the end of a captured frame
//   CLIP             : sticky, a pixel fell outside the buffer
module cam_frame_capture
  import cam_cap_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BYTES_PX = BYTES_PX_DEF,
  parameter int H_PIX    = H_PIX_DEF,
  parameter int V_PIX    = V_PIX_DEF,
  parameter int SRC_W    = SRC_W_DEF
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       PCLK,
  input  logic [DATA_W-1:0]          D,
  input  logic                       HIN,
  input  logic                       VIN,
  input  logic                       ARM,
  input  logic                       MODE,
  input  logic [1:0]                 DECIM,
`ifdef CAP_WINDOW_EN
  input  logic [SRC_W-1:0]           WIN_X0,
  input  logic [SRC_W-1:0]           WIN_Y0,
`endif
  output logic                       WE,
  output logic [$clog2(H_PIX)-1:0]   WADDR_X,
  output logic [$clog2(V_PIX)-1:0]   WADDR_Y,
  output logic [DATA_W*BYTES_PX-1:0] WDATA,
  output logic                       BUSY,
  output logic                       FRAME_DONE,
  output logic                       CLIP
);

  localparam int XW = $clog2(H_PIX);
  localparam int YW = $clog2(V_PIX);
  localparam int PW = DATA_W * BYTES_PX;

  function automatic logic [SRC_W-1:0] sat_inc(input logic [SRC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] d_s;
  logic              hin_s, vin_s, smp;

  cam_sync_edge #(.DATA_W(DATA_W)) u_sync (
    .clk_i    (CLK),
    .rst_ni   (RSTN),
    .pclk_i   (PCLK),
    .d_i      (D),
    .hin_i    (HIN),
    .vin_i    (VIN),
    .d_o      (d_s),
    .hin_o    (hin_s),
    .vin_o    (vin_s),
    .sample_o (smp)
  );

  cap_state_e        state_q, state_d;
  logic [SRC_W-1:0]  src_x_q, src_x_d, src_y_q, src_y_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              hin_prev_q, hin_prev_d;
  logic [PW-1:0]     asm_q, asm_d;
  logic              pix_vld_q, pix_vld_d;
  logic [PW-1:0]     pix_data_q, pix_data_d;
  logic [SRC_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [1:0]        decim_q, decim_d;
  logic              frame_start;

  logic              we_q, we_d, clip_q, clip_d;
  logic [XW-1:0]     waddr_x_q;
  logic [YW-1:0]     waddr_y_q;
  logic [PW-1:0]     wdata_q;

  assign frame_start = (state_q == WAIT_FR) && smp && !vin_s;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // All bus-driven transitions are qualified by the sample strobe so the FSM
  // sees VIN exactly as the pixel path does.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ARM)           state_d = WAIT_VS;
      WAIT_VS: if (smp && vin_s)  state_d = WAIT_FR;
      WAIT_FR: if (smp && !vin_s) state_d = ACTIVE;
      ACTIVE:  if (smp && vin_s)  state_d = DONE;
      DONE:    state_d = MODE ? WAIT_FR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    BUSY       = (state_q != IDLE);
    FRAME_DONE = (state_q == DONE);
  end

  // ---------------- Stage 3: pixel assembly and source counters ----------------
  always_comb begin
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    byte_cnt_d = byte_cnt_q;
    hin_prev_d = hin_prev_q;
    asm_d      = asm_q;
    pix_vld_d  = 1'b0;
    pix_data_d = pix_data_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    decim_d    = decim_q;
    if (smp) begin
      hin_prev_d = hin_s;
      if (frame_start) begin
        src_x_d    = '0;
        src_y_d    = '0;
        byte_cnt_d = '0;
        decim_d    = DECIM;
      end else if (state_q == ACTIVE) begin
        if (hin_s) begin
          asm_d = (asm_q << DATA_W) | PW'(d_s);
          if (byte_cnt_q == BCNT_W'(BYTES_PX - 1)) begin
            byte_cnt_d = '0;
            src_x_d    = sat_inc(src_x_q);
            pix_vld_d  = 1'b1;
            pix_data_d = asm_d;
            pix_x_d    = src_x_q;
            pix_y_d    = src_y_q;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else begin
          // Line end (or blanking): drop any partial pixel; only lines that
          // produced at least one pixel advance the line counter.
          byte_cnt_d = '0;
          src_x_d    = '0;
          if (hin_prev_q && (src_x_q != '0)) src_y_d = sat_inc(src_y_q);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      src_x_q    <= '0;
      src_y_q    <= '0;
      byte_cnt_q <= '0;
      hin_prev_q <= 1'b0;
      pix_vld_q  <= 1'b0;
      decim_q    <= '0;
    end else begin
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      byte_cnt_q <= byte_cnt_d;
      hin_prev_q <= hin_prev_d;
      pix_vld_q  <= pix_vld_d;
      decim_q    <= decim_d;
    end
  end

  // Pixel payload and its coordinates are qualified by pix_vld_q.
  always_ff @(posedge CLK) begin
    asm_q      <= asm_d;
    pix_data_q <= pix_data_d;
    pix_x_q    <= pix_x_d;
    pix_y_q    <= pix_y_d;
  end

  // ---------------- Stage 4: window, decimation, bounds, write ----------------
  logic [SRC_W-1:0] rel_x, rel_y, mask, dst_x, dst_y;
  logic             in_win, phase_ok, oob, take;

`ifdef CAP_WINDOW_EN
  logic [SRC_W-1:0] win_x0_q, win_y0_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      win_x0_q <= '0;
      win_y0_q <= '0;
    end else if (frame_start) begin
      win_x0_q <= WIN_X0;
      win_y0_q <= WIN_Y0;
    end
  end

  assign in_win = (pix_x_q >= win_x0_q) && (pix_y_q >= win_y0_q);
  assign rel_x  = pix_x_q - win_x0_q;
  assign rel_y  = pix_y_q - win_y0_q;
`else
  assign in_win = 1'b1;
  assign rel_x  = pix_x_q;
  assign rel_y  = pix_y_q;
`endif

  assign mask     = SRC_W'((32'd1 << decim_q) - 32'd1);
  assign phase_ok = ((rel_x & mask) == '0) && ((rel_y & mask) == '0);
  assign dst_x    = rel_x >> decim_q;
  assign dst_y    = rel_y >> decim_q;
  assign oob      = (dst_x >= SRC_W'(H_PIX)) || (dst_y >= SRC_W'(V_PIX));
  assign take     = pix_vld_q && in_win && phase_ok;
  assign we_d     = take && !oob;

  always_comb begin
    clip_d = clip_q;
    if ((state_q == IDLE) && ARM) clip_d = 1'b0;
    else if (take && oob)         clip_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      we_q      <= 1'b0;
      clip_q    <= 1'b0;
      waddr_x_q <= '0;
      waddr_y_q <= '0;
      wdata_q   <= '0;
    end else begin
      we_q   <= we_d;
      clip_q <= clip_d;
      if (we_d) begin
        waddr_x_q <= dst_x[XW-1:0];
        waddr_y_q <= dst_y[YW-1:0];
        wdata_q   <= pix_data_q;
      end
    end
  end

  assign WE      = we_q;
  assign WADDR_X = waddr_x_q;
  assign WADDR_Y = waddr_y_q;
  assign WDATA   = wdata_q;
  assign CLIP    = clip_q;

endmodule
